exe_res_arb: RTL and testbench

Arbiter and sequencer for the shared multiplier and shifter that sit behind two Dec0 lanes. Each lane presents a decoded token (node tag, two operands, and the mul/sh class flags produced alongside the decoder). The block grants each shared unit to at most one lane per cycle using round-robin order, and steers that lane's operands and tag to the unit. It tracks occupancy of the non-pipelined multiplier and returns a completion pulse with the originating lane id and tag.

---
 rtl/exe_res_arb_if.sv | 72 +++++++
 rtl/exe_res_arb.sv | 158 +++++++++++++++
 tb/tb_exe_res_arb.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exe_res_arb_if.sv
// Lane-side token bundle and arbiter result bundle
// for the shared multiplier / shifter arbiter.
interface exe_res_arb_if;
  logic        req0_i_arb;
  logic        req1_i_arb;
  logic        mul0_i_arb;
  logic        mul1_i_arb;
  logic        sh0_i_arb;
  logic        sh1_i_arb;
  logic [15:0] node0_i_arb;
  logic [15:0] node1_i_arb;
  logic [31:0] opr0_0_i_arb;
  logic [31:0] opr1_0_i_arb;
  logic [31:0] opr0_1_i_arb;
  logic [31:0] opr1_1_i_arb;

  logic        gnt0_o_arb;
  logic        gnt1_o_arb;
  logic        mul_start_o_arb;
  logic        mul_sel_o_arb;
  logic [31:0] mul_opr0_o_arb;
  logic [31:0] mul_opr1_o_arb;
  logic        sh_start_o_arb;
  logic        sh_sel_o_arb;
  logic [31:0] sh_opr0_o_arb;
  logic [31:0] sh_opr1_o_arb;
  logic        mul_busy_o_arb;
  logic        mul_done_o_arb;
  logic        mul_done_id_o_arb;
  logic [15:0] mul_done_node_o_arb;
  logic        sh_done_o_arb;
  logic        sh_done_id_o_arb;
  logic [15:0] sh_done_node_o_arb;

  modport master (
    output req0_i_arb, req1_i_arb,
    output mul0_i_arb, mul1_i_arb,
    output sh0_i_arb, sh1_i_arb,
    output node0_i_arb, node1_i_arb,
    output opr0_0_i_arb, opr1_0_i_arb,
    output opr0_1_i_arb, opr1_1_i_arb,
    input  gnt0_o_arb, gnt1_o_arb,
    input  mul_start_o_arb, mul_sel_o_arb,
    input  mul_opr0_o_arb, mul_opr1_o_arb,
    input  sh_start_o_arb, sh_sel_o_arb,
    input  sh_opr0_o_arb, sh_opr1_o_arb,
    input  mul_busy_o_arb,
    input  mul_done_o_arb, mul_done_id_o_arb,
    input  mul_done_node_o_arb,
    input  sh_done_o_arb, sh_done_id_o_arb,
    input  sh_done_node_o_arb
  );

  modport slave (
    input  req0_i_arb, req1_i_arb,
    input  mul0_i_arb, mul1_i_arb,
    input  sh0_i_arb, sh1_i_arb,
    input  node0_i_arb, node1_i_arb,
    input  opr0_0_i_arb, opr1_0_i_arb,
    input  opr0_1_i_arb, opr1_1_i_arb,
    output gnt0_o_arb, gnt1_o_arb,
    output mul_start_o_arb, mul_sel_o_arb,
    output mul_opr0_o_arb, mul_opr1_o_arb,
    output sh_start_o_arb, sh_sel_o_arb,
    output sh_opr0_o_arb, sh_opr1_o_arb,
    output mul_busy_o_arb,
    output mul_done_o_arb, mul_done_id_o_arb,
    output mul_done_node_o_arb,
    output sh_done_o_arb, sh_done_id_o_arb,
    output sh_done_node_o_arb
  );
endinterface

// File: rtl/exe_res_arb.sv
// Round-robin arbiter for the shared multiplier and
// shifter behind the two Dec0 lanes.
module exe_res_arb #(
  parameter int MUL_LAT = 3
) (
  input logic         clk,
  input logic         rst,
  exe_res_arb_if.slave arb
);

  localparam logic [3:0] LAT = 4'(MUL_LAT);

  typedef enum logic {IDLE, BUSY} st_e;

  st_e         st_q, st_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rr_mul_q, rr_mul_d;
  logic        rr_sh_q, rr_sh_d;
  logic        lat_id_q, lat_id_d;
  logic [15:0] lat_node_q, lat_node_d;
  logic        mdone_q, mdone_d;
  logic        mdone_id_q, mdone_id_d;
  logic [15:0] mdone_node_q, mdone_node_d;
  logic        sdone_q, sdone_d;
  logic        sdone_id_q, sdone_id_d;
  logic [15:0] sdone_node_q, sdone_node_d;

  logic        m0, m1, s0, s1;
  logic        mul_ok;
  logic        mul_start, mul_sel;
  logic        sh_start, sh_sel;
  logic [15:0] mul_node, sh_node;

  // Class decode; mul wins when both flags are set
  always_comb begin
    m0 = arb.req0_i_arb & arb.mul0_i_arb;
    m1 = arb.req1_i_arb & arb.mul1_i_arb;
    s0 = arb.req0_i_arb & ~arb.mul0_i_arb
       & arb.sh0_i_arb;
    s1 = arb.req1_i_arb & ~arb.mul1_i_arb
       & arb.sh1_i_arb;
  end

  // Multiplier grant: free, or freeing at this edge
  always_comb begin
    mul_ok    = (st_q == IDLE) || (cnt_q == 4'd1);
    mul_start = 1'b0;
    mul_sel   = 1'b0;
    if (rst && mul_ok && (m0 || m1)) begin
      mul_start = 1'b1;
      mul_sel   = (m0 && m1) ? rr_mul_q : m1;
    end
  end

  // Shifter grant: pipelined, accepts every cycle
  always_comb begin
    sh_start = 1'b0;
    sh_sel   = 1'b0;
    if (rst && (s0 || s1)) begin
      sh_start = 1'b1;
      sh_sel   = (s0 && s1) ? rr_sh_q : s1;
    end
  end

  assign mul_node = mul_sel ? arb.node1_i_arb
                            : arb.node0_i_arb;
  assign sh_node  = sh_sel ? arb.node1_i_arb
                           : arb.node0_i_arb;

  assign arb.gnt0_o_arb = (mul_start & ~mul_sel)
                        | (sh_start & ~sh_sel);
  assign arb.gnt1_o_arb = (mul_start & mul_sel)
                        | (sh_start & sh_sel);

  assign arb.mul_start_o_arb = mul_start;
  assign arb.mul_sel_o_arb   = mul_sel;
  assign arb.mul_opr0_o_arb  = mul_sel
                             ? arb.opr0_1_i_arb
                             : arb.opr0_0_i_arb;
  assign arb.mul_opr1_o_arb  = mul_sel
                             ? arb.opr1_1_i_arb
                             : arb.opr1_0_i_arb;
  assign arb.sh_start_o_arb  = sh_start;
  assign arb.sh_sel_o_arb    = sh_sel;
  assign arb.sh_opr0_o_arb   = sh_sel
                             ? arb.opr0_1_i_arb
                             : arb.opr0_0_i_arb;
  assign arb.sh_opr1_o_arb   = sh_sel
                             ? arb.opr1_1_i_arb
                             : arb.opr1_0_i_arb;

  assign arb.mul_busy_o_arb      = (st_q == BUSY);
  assign arb.mul_done_o_arb      = mdone_q;
  assign arb.mul_done_id_o_arb   = mdone_id_q;
  assign arb.mul_done_node_o_arb = mdone_node_q;
  assign arb.sh_done_o_arb       = sdone_q;
  assign arb.sh_done_id_o_arb    = sdone_id_q;
  assign arb.sh_done_node_o_arb  = sdone_node_q;

  // Next state: occupancy count, tags, pointers
  always_comb begin
    cnt_d      = cnt_q;
    lat_id_d   = lat_id_q;
    lat_node_d = lat_node_q;
    if (mul_start) begin
      cnt_d      = LAT;
      lat_id_d   = mul_sel;
      lat_node_d = mul_node;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
    st_d = (cnt_d != 4'd0) ? BUSY : IDLE;

    // Done is shown in the last occupied cycle
    mdone_d      = (cnt_d == 4'd1);
    mdone_id_d   = mdone_d & lat_id_d;
    mdone_node_d = mdone_d ? lat_node_d : 16'h0;

    sdone_d      = sh_start;
    sdone_id_d   = sh_sel;
    sdone_node_d = sh_start ? sh_node : 16'h0;

    rr_mul_d = mul_start ? ~mul_sel : rr_mul_q;
    rr_sh_d  = sh_start ? ~sh_sel : rr_sh_q;
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q         <= IDLE;
      cnt_q        <= 4'd0;
      rr_mul_q     <= 1'b0;
      rr_sh_q      <= 1'b0;
      lat_id_q     <= 1'b0;
      lat_node_q   <= 16'h0;
      mdone_q      <= 1'b0;
      mdone_id_q   <= 1'b0;
      mdone_node_q <= 16'h0;
      sdone_q      <= 1'b0;
      sdone_id_q   <= 1'b0;
      sdone_node_q <= 16'h0;
    end else begin
      st_q         <= st_d;
      cnt_q        <= cnt_d;
      rr_mul_q     <= rr_mul_d;
      rr_sh_q      <= rr_sh_d;
      lat_id_q     <= lat_id_d;
      lat_node_q   <= lat_node_d;
      mdone_q      <= mdone_d;
      mdone_id_q   <= mdone_id_d;
      mdone_node_q <= mdone_node_d;
      sdone_q      <= sdone_d;
      sdone_id_q   <= sdone_id_d;
      sdone_node_q <= sdone_node_d;
    end
  end

endmodule

// File: tb/tb_exe_res_arb.sv
// Bench for exe_res_arb: directed scenarios on
// MUL_LAT=3 and MUL_LAT=1 plus a random model run.
module tb_exe_res_arb;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  exe_res_arb_if ia();
  exe_res_arb_if ib();

  exe_res_arb #(.MUL_LAT(3)) u_a (
    .clk(clk), .rst(rst), .arb(ia.slave)
  );
  exe_res_arb #(.MUL_LAT(1)) u_b (
    .clk(clk), .rst(rst), .arb(ib.slave)
  );

  typedef struct packed {
    logic        req, mul, sh;
    logic [15:0] node;
    logic [31:0] a, b;
  } tok_t;

  typedef struct packed {
    logic        g0, g1, ms, msel;
    logic [31:0] mo0, mo1;
    logic        ss, ssel;
    logic [31:0] so0, so1;
    logic        busy, md, mid;
    logic [15:0] mnode;
    logic        sd, sid;
    logic [15:0] snode;
  } obs_t;

  localparam tok_t Z = '0;

  function automatic tok_t mk(bit r, bit m, bit s,
      logic [15:0] n, logic [31:0] a, logic [31:0] b);
    tok_t t;
    t.req = r; t.mul = m; t.sh = s;
    t.node = n; t.a = a; t.b = b;
    return t;
  endfunction

  task automatic drive(input int w,
      input tok_t t0, input tok_t t1);
    if (w == 0) begin
      ia.req0_i_arb = t0.req; ia.req1_i_arb = t1.req;
      ia.mul0_i_arb = t0.mul; ia.mul1_i_arb = t1.mul;
      ia.sh0_i_arb = t0.sh; ia.sh1_i_arb = t1.sh;
      ia.node0_i_arb = t0.node; ia.node1_i_arb = t1.node;
      ia.opr0_0_i_arb = t0.a; ia.opr1_0_i_arb = t0.b;
      ia.opr0_1_i_arb = t1.a; ia.opr1_1_i_arb = t1.b;
    end else begin
      ib.req0_i_arb = t0.req; ib.req1_i_arb = t1.req;
      ib.mul0_i_arb = t0.mul; ib.mul1_i_arb = t1.mul;
      ib.sh0_i_arb = t0.sh; ib.sh1_i_arb = t1.sh;
      ib.node0_i_arb = t0.node; ib.node1_i_arb = t1.node;
      ib.opr0_0_i_arb = t0.a; ib.opr1_0_i_arb = t0.b;
      ib.opr0_1_i_arb = t1.a; ib.opr1_1_i_arb = t1.b;
    end
  endtask

  task automatic sample(input int w, output obs_t o);
    if (w == 0) begin
      o = {ia.gnt0_o_arb, ia.gnt1_o_arb,
           ia.mul_start_o_arb, ia.mul_sel_o_arb,
           ia.mul_opr0_o_arb, ia.mul_opr1_o_arb,
           ia.sh_start_o_arb, ia.sh_sel_o_arb,
           ia.sh_opr0_o_arb, ia.sh_opr1_o_arb,
           ia.mul_busy_o_arb, ia.mul_done_o_arb,
           ia.mul_done_id_o_arb, ia.mul_done_node_o_arb,
           ia.sh_done_o_arb, ia.sh_done_id_o_arb,
           ia.sh_done_node_o_arb};
    end else begin
      o = {ib.gnt0_o_arb, ib.gnt1_o_arb,
           ib.mul_start_o_arb, ib.mul_sel_o_arb,
           ib.mul_opr0_o_arb, ib.mul_opr1_o_arb,
           ib.sh_start_o_arb, ib.sh_sel_o_arb,
           ib.sh_opr0_o_arb, ib.sh_opr1_o_arb,
           ib.mul_busy_o_arb, ib.mul_done_o_arb,
           ib.mul_done_id_o_arb, ib.mul_done_node_o_arb,
           ib.sh_done_o_arb, ib.sh_done_id_o_arb,
           ib.sh_done_node_o_arb};
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(0, Z, Z);
    drive(1, Z, Z);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    obs_t o;
    rst = 1'b0;
    for (int w = 0; w < 2; w++) begin
      drive(w, mk(1, 1, 0, 16'h1, 1, 2),
               mk(1, 0, 1, 16'h2, 3, 4));
    end
    @(negedge clk);
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      sample(w, o);
      checks++;
      if ({o.g0, o.g1, o.ms, o.msel, o.ss, o.ssel}
          !== 6'b0) begin
        failures++;
        $display("FAIL reset_ctl w=%0d got=%b want=0",
          w, {o.g0, o.g1, o.ms, o.msel, o.ss, o.ssel});
      end
      checks++;
      if ({o.busy, o.md, o.mid, o.mnode,
           o.sd, o.sid, o.snode} !== 37'b0) begin
        failures++;
        $display("FAIL reset_regs w=%0d got=%h want=0",
          w, {o.busy, o.md, o.mid, o.mnode,
              o.sd, o.sid, o.snode});
      end
    end
    do_reset();
  endtask

  task automatic test_single_mul();
    obs_t o;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive(0, c == 0 ? mk(1, 1, 0, 16'h0011, 5, 7)
                      : Z, Z);
      #1 sample(0, o);
      if (c == 0) begin
        checks++;
        if ({o.g0, o.g1, o.ms, o.msel, o.mo0, o.mo1}
            !== {4'b1010, 32'd5, 32'd7}) begin
          failures++;
          $display("FAIL single_launch got=%b %0d %0d",
            {o.g0, o.g1, o.ms, o.msel}, o.mo0, o.mo1);
        end
      end
      checks++;
      if (o.busy !== (c >= 1 && c <= 3)) begin
        failures++;
        $display("FAIL single_busy c=%0d got=%b", c,
          o.busy);
      end
      checks++;
      if (o.md !== (c == 3)) begin
        failures++;
        $display("FAIL single_done c=%0d got=%b", c,
          o.md);
      end
      if (c == 3) begin
        checks++;
        if ({o.mid, o.mnode} !== {1'b0, 16'h0011})
        begin
          failures++;
          $display("FAIL single_tag got=%b %h want 0 0011",
            o.mid, o.mnode);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_rr_mul();
    obs_t o;
    bit es, esel;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      drive(0, mk(1, 1, 0, 16'h100, 100, 1),
               mk(1, 1, 0, 16'h200, 200, 2));
      #1 sample(0, o);
      es   = (c % 3 == 0);
      esel = ((c / 3) % 2 == 1);
      checks++;
      if ({o.ms, o.g0, o.g1} !==
          {es, es && !esel, es && esel}) begin
        failures++;
        $display("FAIL rr_mul c=%0d got=%b want=%b", c,
          {o.ms, o.g0, o.g1},
          {es, es && !esel, es && esel});
      end
      if (es) begin
        checks++;
        if ({o.msel, o.mo0} !==
            {esel, esel ? 32'd200 : 32'd100}) begin
          failures++;
          $display("FAIL rr_mul_sel c=%0d got=%b %0d",
            c, o.msel, o.mo0);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mul_sh();
    obs_t o;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      if (c == 0)
        drive(0, mk(1, 1, 0, 16'h00a0, 3, 4),
                 mk(1, 0, 1, 16'h00b1, 9, 2));
      else
        drive(0, Z, Z);
      #1 sample(0, o);
      if (c == 0) begin
        checks++;
        if ({o.g0, o.g1, o.ms, o.msel, o.ss, o.ssel,
             o.so0, o.so1} !==
            {6'b111011, 32'd9, 32'd2}) begin
          failures++;
          $display("FAIL mulsh_grant got=%b %0d %0d",
            {o.g0, o.g1, o.ms, o.msel, o.ss, o.ssel},
            o.so0, o.so1);
        end
      end
      checks++;
      if (o.sd !== (c == 1) || o.md !== (c == 3)) begin
        failures++;
        $display("FAIL mulsh_done c=%0d got=%b%b", c,
          o.sd, o.md);
      end
      if (c == 1) begin
        checks++;
        if ({o.sid, o.snode} !== {1'b1, 16'h00b1}) begin
          failures++;
          $display("FAIL mulsh_shtag got=%b %h", o.sid,
            o.snode);
        end
      end
      if (c == 3) begin
        checks++;
        if ({o.mid, o.mnode} !== {1'b0, 16'h00a0}) begin
          failures++;
          $display("FAIL mulsh_multag got=%b %h", o.mid,
            o.mnode);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sh_rr();
    obs_t o;
    bit esel, eid;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(0, mk(1, 0, 1, 16'h0a0a, 1, 1),
               mk(1, 0, 1, 16'h0b0b, 2, 2));
      #1 sample(0, o);
      esel = (c % 2 == 1);
      checks++;
      if ({o.ss, o.ssel, o.g0, o.g1, o.ms} !==
          {1'b1, esel, !esel, esel, 1'b0}) begin
        failures++;
        $display("FAIL sh_rr c=%0d got=%b", c,
          {o.ss, o.ssel, o.g0, o.g1, o.ms});
      end
      if (c >= 1) begin
        eid = ((c - 1) % 2 == 1);
        checks++;
        if ({o.sd, o.sid, o.snode} !==
            {1'b1, eid, eid ? 16'h0b0b : 16'h0a0a}) begin
          failures++;
          $display("FAIL sh_rr_done c=%0d got=%b %b %h",
            c, o.sd, o.sid, o.snode);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    do_reset();
    drive(0, mk(1, 1, 0, 16'h0c0c, 1, 1), Z);
    @(negedge clk);
    drive(0, Z, Z);
    #1 sample(0, o);
    checks++;
    if (o.busy !== 1'b1) begin
      failures++;
      $display("FAIL rmid_busy_pre got=%b want=1",
        o.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(0, Z, mk(1, 1, 0, 16'h0d0d, 6, 6));
    #1 sample(0, o);
    checks++;
    if ({o.busy, o.g1, o.ms, o.md} !== 4'b0) begin
      failures++;
      $display("FAIL rmid_in_reset got=%b want=0000",
        {o.busy, o.g1, o.ms, o.md});
    end
    @(negedge clk);
    rst = 1'b1;
    for (int d = 0; d < 6; d++) begin
      if (d > 0) drive(0, Z, Z);
      #1 sample(0, o);
      if (d == 0) begin
        checks++;
        if ({o.g1, o.ms, o.msel, o.busy} !== 4'b1110)
        begin
          failures++;
          $display("FAIL rmid_regrant got=%b want=1110",
            {o.g1, o.ms, o.msel, o.busy});
        end
      end
      checks++;
      if (o.md !== (d == 3) ||
          (d == 3 && {o.mid, o.mnode} !==
                     {1'b1, 16'h0d0d})) begin
        failures++;
        $display("FAIL rmid_done d=%0d got=%b %b %h",
          d, o.md, o.mid, o.mnode);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lat1();
    obs_t o;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(1, mk(1, 1, 0, 16'h0e0e, c, 1),
               mk(1, 0, 0, 16'h0f0f, 2, 2));
      #1 sample(1, o);
      checks++;
      if ({o.ms, o.msel, o.g0, o.g1, o.ss} !==
          5'b10100) begin
        failures++;
        $display("FAIL lat1_grant c=%0d got=%b", c,
          {o.ms, o.msel, o.g0, o.g1, o.ss});
      end
      checks++;
      if (o.md !== (c >= 1) ||
          (c >= 1 && o.mid !== 1'b0)) begin
        failures++;
        $display("FAIL lat1_done c=%0d got=%b %b", c,
          o.md, o.mid);
      end
      @(negedge clk);
    end
  endtask

  // Random stream checked against a cycle model:
  // launch times, priority lanes, pending completions.
  task automatic test_random(input int w,
      input int lat, input int n);
    obs_t o;
    tok_t t[2];
    int ls, k;
    bit mpri, spri, lsid;
    logic [15:0] lsnode, pnode;
    bit pvs, pid;
    bit m0, m1, s0, s1, ok;
    bit ems, emsel, ess, essel, eg0, eg1;
    bit ebusy, emd;
    tok_t tm, tsh;
    do_reset();
    t[0] = Z; t[1] = Z;
    ls = -1; mpri = 0; spri = 0; lsid = 0;
    lsnode = 0; pvs = 0; pid = 0; pnode = 0;
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!t[i].req && $urandom_range(0, 9) < 6)
        begin
          k = $urandom_range(0, 2);
          t[i] = mk(1, k != 1, k != 0,
            16'($urandom), $urandom, $urandom);
        end
      end
      drive(w, t[0], t[1]);
      #1 sample(w, o);
      m0 = t[0].req && t[0].mul;
      m1 = t[1].req && t[1].mul;
      s0 = t[0].req && !t[0].mul && t[0].sh;
      s1 = t[1].req && !t[1].mul && t[1].sh;
      ok = (ls < 0) || (c >= ls + lat);
      ems = ok && (m0 || m1);
      emsel = ems && ((m0 && m1) ? mpri : m1);
      ess = s0 || s1;
      essel = ess && ((s0 && s1) ? spri : s1);
      eg0 = (ems && !emsel) || (ess && !essel);
      eg1 = (ems && emsel) || (ess && essel);
      ebusy = (ls >= 0) && (c > ls) && (c <= ls + lat);
      emd = (ls >= 0) && (c == ls + lat);
      tm = emsel ? t[1] : t[0];
      tsh = essel ? t[1] : t[0];
      checks++;
      if ({o.g0, o.g1, o.ms, o.msel, o.ss, o.ssel} !==
          {eg0, eg1, ems, emsel, ess, essel}) begin
        failures++;
        $display("FAIL rnd_ctl w=%0d c=%0d got=%b want=%b",
          w, c, {o.g0, o.g1, o.ms, o.msel, o.ss, o.ssel},
          {eg0, eg1, ems, emsel, ess, essel});
      end
      if (ems) begin
        checks++;
        if ({o.mo0, o.mo1} !== {tm.a, tm.b}) begin
          failures++;
          $display("FAIL rnd_mopr w=%0d c=%0d got=%h want=%h",
            w, c, {o.mo0, o.mo1}, {tm.a, tm.b});
        end
      end
      if (ess) begin
        checks++;
        if ({o.so0, o.so1} !== {tsh.a, tsh.b}) begin
          failures++;
          $display("FAIL rnd_sopr w=%0d c=%0d got=%h want=%h",
            w, c, {o.so0, o.so1}, {tsh.a, tsh.b});
        end
      end
      checks++;
      if ({o.busy, o.md, o.sd} !== {ebusy, emd, pvs})
      begin
        failures++;
        $display("FAIL rnd_stat w=%0d c=%0d got=%b want=%b",
          w, c, {o.busy, o.md, o.sd}, {ebusy, emd, pvs});
      end
      if (emd) begin
        checks++;
        if ({o.mid, o.mnode} !== {lsid, lsnode}) begin
          failures++;
          $display("FAIL rnd_mtag w=%0d c=%0d got=%b %h want=%b %h",
            w, c, o.mid, o.mnode, lsid, lsnode);
        end
      end
      if (pvs) begin
        checks++;
        if ({o.sid, o.snode} !== {pid, pnode}) begin
          failures++;
          $display("FAIL rnd_stag w=%0d c=%0d got=%b %h want=%b %h",
            w, c, o.sid, o.snode, pid, pnode);
        end
      end
      if (ems) begin
        ls = c; lsid = emsel; lsnode = tm.node;
        mpri = !emsel;
      end
      pvs = ess; pid = essel; pnode = tsh.node;
      if (ess) spri = !essel;
      if (eg0) t[0].req = 1'b0;
      if (eg1) t[1].req = 1'b0;
      @(negedge clk);
    end
    drive(w, Z, Z);
  endtask

  initial begin
    drive(0, Z, Z);
    drive(1, Z, Z);
    @(negedge clk);
    test_reset();
    test_single_mul();
    test_rr_mul();
    test_mul_sh();
    test_sh_rr();
    test_reset_mid();
    test_lat1();
    test_random(0, 3, 400);
    test_random(1, 1, 400);
    $display("TB_RESULT checks=%0d failures=%0d",
      checks, failures);
    $finish;
  end

endmodule
